// File: rtl/control_sequencer.sv
// Microcoded step sequencer driving every bus strobe of the 8-bit bus machine.
// Optional macro SEQ_EARLY_END_EN: an empty execute step returns straight to fetch.
module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STEPS    = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               instruction,
    input  logic                     flag_carry,
    input  logic                     flag_zero,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     halt,
    output logic                     mar_in,
    output logic                     ram_in,
    output logic                     ram_out,
    output logic                     ir_in,
    output logic                     ir_out,
    output logic                     a_in,
    output logic                     a_out,
    output logic                     b_in,
    output logic                     out_in,
    output logic                     alu_read,
    output logic                     alu_sub,
    output logic                     alu_set_flags,
    output logic                     pc_inc,
    output logic                     pc_out,
    output logic                     jump
);

    localparam int STEP_W = $clog2(STEPS);

    localparam logic [STEP_W-1:0] T0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic ram_out;
        logic ir_in;
        logic pc_inc;
        logic ir_out;
        logic ram_in;
        logic a_in;
        logic a_out;
        logic b_in;
        logic out_in;
        logic alu_read;
        logic alu_sub;
        logic alu_set_flags;
        logic jump;
    } ctrl_t;

    logic [STEP_W-1:0]   step_q, step_d;
    logic                halted_q, halted_d;
    logic [OPCODE_W-1:0] opcode;
    ctrl_t               cw_raw;
    ctrl_t               cw;
    logic                unused_operand;

    assign opcode         = instruction[7 -: OPCODE_W];
    assign unused_operand = ^instruction[7-OPCODE_W:0];

    // Microcode: fetch is shared, execute decodes on opcode; unlisted opcodes do nothing.
    always_comb begin
        cw_raw = '0;
        if (step_q == T0) begin
            cw_raw.pc_out = 1'b1;
            cw_raw.mar_in = 1'b1;
        end else if (step_q == T1) begin
            cw_raw.ram_out = 1'b1;
            cw_raw.ir_in   = 1'b1;
            cw_raw.pc_inc  = 1'b1;
        end else begin
            case (opcode)
                OP_LDA: begin
                    if (step_q == T2) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.mar_in = 1'b1;
                    end else if (step_q == T3) begin
                        cw_raw.ram_out = 1'b1;
                        cw_raw.a_in    = 1'b1;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (step_q == T2) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.mar_in = 1'b1;
                    end else if (step_q == T3) begin
                        cw_raw.ram_out = 1'b1;
                        cw_raw.b_in    = 1'b1;
                    end else if (step_q == T4) begin
                        cw_raw.alu_read      = 1'b1;
                        cw_raw.a_in          = 1'b1;
                        cw_raw.alu_set_flags = 1'b1;
                        cw_raw.alu_sub       = (opcode == OP_SUB);
                    end
                end
                OP_STA: begin
                    if (step_q == T2) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.mar_in = 1'b1;
                    end else if (step_q == T3) begin
                        cw_raw.a_out  = 1'b1;
                        cw_raw.ram_in = 1'b1;
                    end
                end
                OP_LDI: begin
                    if (step_q == T2) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.a_in   = 1'b1;
                    end
                end
                OP_JMP: begin
                    if (step_q == T2) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.jump   = 1'b1;
                    end
                end
                // Conditional jumps look at the flags only during their T2 step.
                OP_JC: begin
                    if (step_q == T2 && flag_carry) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.jump   = 1'b1;
                    end
                end
                OP_JZ: begin
                    if (step_q == T2 && flag_zero) begin
                        cw_raw.ir_out = 1'b1;
                        cw_raw.jump   = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (step_q == T2) begin
                        cw_raw.a_out  = 1'b1;
                        cw_raw.out_in = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset and the halted state silence every strobe without adding a cycle of latency.
    assign cw = (reset || halted_q) ? '0 : cw_raw;

    assign pc_out        = cw.pc_out;
    assign mar_in        = cw.mar_in;
    assign ram_out       = cw.ram_out;
    assign ir_in         = cw.ir_in;
    assign pc_inc        = cw.pc_inc;
    assign ir_out        = cw.ir_out;
    assign ram_in        = cw.ram_in;
    assign a_in          = cw.a_in;
    assign a_out         = cw.a_out;
    assign b_in          = cw.b_in;
    assign out_in        = cw.out_in;
    assign alu_read      = cw.alu_read;
    assign alu_sub       = cw.alu_sub;
    assign alu_set_flags = cw.alu_set_flags;
    assign jump          = cw.jump;

    assign step = step_q;
    assign halt = halted_q && !reset;

    // HLT freezes the counter at T2 so the trace shows where the machine stopped.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (opcode == OP_HLT && step_q == T2) begin
                halted_d = 1'b1;
            end else if (step_q >= LAST) begin
                step_d = T0;
`ifdef SEQ_EARLY_END_EN
            end else if (step_q >= T2 && cw_raw == '0) begin
                step_d = T0;
`endif
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, decode, jumps, halt and reset recovery.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       flag_carry = 1'b0;
    logic       flag_zero = 1'b0;
    logic [2:0] step;
    logic       halt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, out_in;
    logic       alu_read, alu_sub, alu_set_flags, pc_inc, pc_out, jump;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    localparam logic [14:0] C_PCO  = 15'h4000;
    localparam logic [14:0] C_MARI = 15'h2000;
    localparam logic [14:0] C_RAMO = 15'h1000;
    localparam logic [14:0] C_IRI  = 15'h0800;
    localparam logic [14:0] C_PCI  = 15'h0400;
    localparam logic [14:0] C_IRO  = 15'h0200;
    localparam logic [14:0] C_RAMI = 15'h0100;
    localparam logic [14:0] C_AI   = 15'h0080;
    localparam logic [14:0] C_AO   = 15'h0040;
    localparam logic [14:0] C_BI   = 15'h0020;
    localparam logic [14:0] C_OI   = 15'h0010;
    localparam logic [14:0] C_ALUR = 15'h0008;
    localparam logic [14:0] C_SUB  = 15'h0004;
    localparam logic [14:0] C_SF   = 15'h0002;
    localparam logic [14:0] C_J    = 15'h0001;
    localparam logic [14:0] Z      = 15'h0000;
    localparam logic [14:0] F0     = C_PCO | C_MARI;
    localparam logic [14:0] F1     = C_RAMO | C_IRI | C_PCI;

    logic [14:0] cw;
    assign cw = {pc_out, mar_in, ram_out, ir_in, pc_inc, ir_out, ram_in, a_in, a_out,
                 b_in, out_in, alu_read, alu_sub, alu_set_flags, jump};

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .flag_carry(flag_carry), .flag_zero(flag_zero),
        .step(step), .halt(halt),
        .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .out_in(out_in),
        .alu_read(alu_read), .alu_sub(alu_sub), .alu_set_flags(alu_set_flags),
        .pc_inc(pc_inc), .pc_out(pc_out), .jump(jump)
    );

    // At most one register writer and one bus driver may be active in any cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if ($countones({a_in, b_in, mar_in, ram_in, ir_in, out_in}) > 1 ||
                $countones({pc_out, ram_out, ir_out, a_out, alu_read}) > 1) begin
                errors++;
                $display("FAIL bus_exclusive: step=%0d cw=%h, required at most one writer and one driver",
                         step, cw);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        instruction = 8'h00;
        flag_carry = 1'b0;
        flag_zero = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] ecw [6];
        logic [2:0]  est [6];
`ifdef SEQ_EARLY_END_EN
        ecw = '{F0, F1, Z, F0, F1, Z};
        est = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
`else
        ecw = '{F0, F1, Z, Z, Z, F0};
        est = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
`endif
        apply_reset();
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (step !== 3'd0) begin
            errors++;
            $display("FAIL reset_step: got %0d, expected 0", step);
        end
        checks++;
        if (cw !== Z || halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cw=%h halt=%b, expected cw=0000 halt=0", cw, halt);
        end
        mon_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            reset = 1'b0;
            @(negedge clock);
            checks++;
            if (step !== est[c] || cw !== ecw[c] || halt !== 1'b0) begin
                errors++;
                $display("FAIL nop_cycle%0d: step=%0d cw=%h halt=%b, expected step=%0d cw=%h halt=0",
                         c, step, cw, halt, est[c], ecw[c]);
            end
        end
    endtask

    task automatic test_decode();
        logic [7:0]  ins  [8];
        int          ncyc [8];
        logic [14:0] exp  [8][5];
        ins  = '{8'h1A, 8'h4B, 8'h63, 8'hE0, 8'h9C, 8'h2F, 8'h3F, 8'h55};
        ncyc = '{5, 5, 4, 4, 3, 5, 5, 4};
        exp  = '{'{F0, F1, C_IRO | C_MARI, C_RAMO | C_AI, Z},
                 '{F0, F1, C_IRO | C_MARI, C_AO | C_RAMI, Z},
                 '{F0, F1, C_IRO | C_J, Z, Z},
                 '{F0, F1, C_AO | C_OI, Z, Z},
                 '{F0, F1, Z, Z, Z},
                 '{F0, F1, C_IRO | C_MARI, C_RAMO | C_BI, C_ALUR | C_AI | C_SF},
                 '{F0, F1, C_IRO | C_MARI, C_RAMO | C_BI, C_ALUR | C_AI | C_SF | C_SUB},
                 '{F0, F1, C_IRO | C_AI, Z, Z}};
        for (int e = 0; e < 8; e++) begin
            apply_reset();
            for (int c = 0; c < ncyc[e]; c++) begin
                @(posedge clock); #1;
                reset = 1'b0;
                instruction = ins[e];
                @(negedge clock);
                checks++;
                if (step !== 3'(c) || cw !== exp[e][c]) begin
                    errors++;
                    $display("FAIL decode_%h_T%0d: step=%0d cw=%h, expected step=%0d cw=%h",
                             ins[e], c, step, cw, c, exp[e][c]);
                end
            end
        end
    endtask

    task automatic test_jumps();
        logic [7:0]  ins [6];
        logic        fc  [6];
        logic        fz  [6];
        logic [14:0] t2  [6];
        logic [14:0] want;
        ins = '{8'h74, 8'h74, 8'h74, 8'h84, 8'h84, 8'h84};
        fc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        fz  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t2  = '{Z, C_IRO | C_J, Z, Z, C_IRO | C_J, Z};
        for (int e = 0; e < 6; e++) begin
            apply_reset();
            for (int c = 0; c < 3; c++) begin
                @(posedge clock); #1;
                reset = 1'b0;
                instruction = ins[e];
                flag_carry = (c == 2) ? fc[e] : ~fc[e];
                flag_zero  = (c == 2) ? fz[e] : ~fz[e];
                want = (c == 0) ? F0 : (c == 1) ? F1 : t2[e];
                @(negedge clock);
                checks++;
                if (step !== 3'(c) || cw !== want) begin
                    errors++;
                    $display("FAIL jump_%h_c%b_z%b_T%0d: step=%0d cw=%h, expected step=%0d cw=%h",
                             ins[e], fc[e], fz[e], c, step, cw, c, want);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [14:0] ecw [3];
        ecw = '{F0, F1, Z};
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            reset = 1'b0;
            instruction = 8'hF0;
            @(negedge clock);
            checks++;
            if (step !== 3'(c) || cw !== ecw[c] || halt !== 1'b0) begin
                errors++;
                $display("FAIL hlt_T%0d: step=%0d cw=%h halt=%b, expected step=%0d cw=%h halt=0",
                         c, step, cw, halt, c, ecw[c]);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            instruction = c[0] ? 8'h2F : 8'h74;
            flag_carry = c[0];
            @(negedge clock);
            checks++;
            if (step !== 3'd2 || cw !== Z || halt !== 1'b1) begin
                errors++;
                $display("FAIL halted_c%0d: step=%0d cw=%h halt=%b, expected step=2 cw=0000 halt=1",
                         c, step, cw, halt);
            end
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (cw !== Z || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset_cycle: cw=%h halt=%b, expected cw=0000 halt=0", cw, halt);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        instruction = 8'h00;
        flag_carry = 1'b0;
        @(negedge clock);
        checks++;
        if (step !== 3'd0 || cw !== F0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_recover: step=%0d cw=%h halt=%b, expected step=0 cw=%h halt=0",
                     step, cw, halt, F0);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            reset = 1'b0;
            instruction = 8'h2F;
            @(negedge clock);
            checks++;
            if (step !== 3'(c)) begin
                errors++;
                $display("FAIL mid_T%0d: step=%0d, expected %0d", c, step, c);
            end
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (step !== 3'd3 || cw !== Z) begin
            errors++;
            $display("FAIL mid_reset_T3: step=%0d cw=%h, expected step=3 cw=0000", step, cw);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (step !== 3'd0 || cw !== F0) begin
            errors++;
            $display("FAIL mid_refetch_T0: step=%0d cw=%h, expected step=0 cw=%h", step, cw, F0);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (step !== 3'd1 || cw !== F1) begin
            errors++;
            $display("FAIL mid_refetch_T1: step=%0d cw=%h, expected step=1 cw=%h", step, cw, F1);
        end
    endtask

    task automatic test_ldi_length();
        logic [14:0] ecw [6];
        logic [2:0]  est [6];
`ifdef SEQ_EARLY_END_EN
        ecw = '{F0, F1, C_IRO | C_AI, Z, F0, F1};
        est = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
`else
        ecw = '{F0, F1, C_IRO | C_AI, Z, Z, F0};
        est = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
`endif
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            reset = 1'b0;
            instruction = 8'h57;
            @(negedge clock);
            checks++;
            if (step !== est[c] || cw !== ecw[c]) begin
                errors++;
                $display("FAIL ldi_cycle%0d: step=%0d cw=%h, expected step=%0d cw=%h",
                         c, step, cw, est[c], ecw[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_jumps();
        test_halt();
        test_reset_mid();
        test_ldi_length();
        @(posedge clock); #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
